// File: rtl/modinv_stream.sv
// Streaming modular-inverse engine: iterative extended Euclid with bit-serial restoring
// division and a fused shift-add quotient*t1 product, one quotient bit per cycle.
module modinv_stream #(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned ITER_W = 11
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  num,
  input  logic [WIDTH-1:0]  modulus,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  inv,
  output logic [WIDTH-1:0]  gcd,
  output logic              err,
  output logic [ITER_W-1:0] iters
);

  localparam int unsigned TW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StDiv,
    StUpdate,
    StFinal,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]  a_q, b_q, r_q, mod_q;
  logic [TW-1:0]     t0_q, t1_q, p_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  inv_q, gcd_q;
  logic              err_q;
  logic [ITER_W-1:0] iters_q;

  logic             mod_small;
  logic [WIDTH:0]   r_shift;
  logic             r_ge;
  logic [WIDTH-1:0] r_sub;
  logic [WIDTH-1:0] t0_wrap;
  logic             err_n;

  // r stays below b, so r_shift < 2b and the difference always fits in WIDTH bits.
  // a is shifted left during DIV so its MSB is the next dividend bit.
  always_comb begin
    mod_small = (mod_q[WIDTH-1:1] == '0);
    r_shift   = {r_q, a_q[WIDTH-1]};
    r_ge      = (r_shift >= {1'b0, b_q});
    r_sub     = r_shift[WIDTH-1:0] - b_q;
    t0_wrap   = t0_q[WIDTH-1:0] + mod_q;
    err_n     = (a_q != WIDTH'(1)) || mod_small;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (s_valid) state_d = StCheck;
      StCheck:  state_d = (mod_small || (b_q == '0)) ? StFinal : StDiv;
      StDiv:    if (cnt_q == '0) state_d = StUpdate;
      StUpdate: state_d = StCheck;
      StFinal:  state_d = StDone;
      StDone:   if (m_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      mod_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      inv_q   <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (s_valid) begin
            a_q     <= modulus;
            b_q     <= num;
            mod_q   <= modulus;
            t0_q    <= '0;
            t1_q    <= TW'(1);
            iters_q <= '0;
          end
        end
        StCheck: begin
          r_q   <= '0;
          p_q   <= '0;
          cnt_q <= CW'(WIDTH - 1);
        end
        StDiv: begin
          // Horner form of sum(q[i] * t1 << i): no barrel shifter needed.
          a_q   <= a_q << 1;
          cnt_q <= cnt_q - 1'b1;
          p_q   <= {p_q[TW-2:0], 1'b0} + (r_ge ? t1_q : '0);
          r_q   <= r_ge ? r_sub : r_shift[WIDTH-1:0];
        end
        StUpdate: begin
          a_q  <= b_q;
          b_q  <= r_q;
          t0_q <= t1_q;
          t1_q <= t0_q - p_q;
          if (iters_q != '1) iters_q <= iters_q + 1'b1;
        end
        StFinal: begin
          gcd_q <= a_q;
          err_q <= err_n;
          inv_q <= err_n ? '0 : (t0_q[TW-1] ? t0_wrap : t0_q[WIDTH-1:0]);
        end
        default: ;
      endcase
    end
  end

  assign s_ready = (state_q == StIdle);
  assign m_valid = (state_q == StDone);
  assign inv     = inv_q;
  assign gcd     = gcd_q;
  assign err     = err_q;
  assign iters   = iters_q;

endmodule

// File: tb/tb_modinv_stream.sv
// Directed bench for modinv_stream at WIDTH=8: hand-computed inverses, gcds, division
// counts and latencies, plus backpressure and mid-division reset.
module tb_modinv_stream;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ITER_W = 11;

  logic              aclk = 1'b0;
  logic              areset;
  logic              s_valid;
  logic              s_ready;
  logic [WIDTH-1:0]  num;
  logic [WIDTH-1:0]  modulus;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  inv;
  logic [WIDTH-1:0]  gcd;
  logic              err;
  logic [ITER_W-1:0] iters;

  int n_total = 0;
  int n_pass  = 0;

  modinv_stream #(
    .WIDTH  (WIDTH),
    .ITER_W (ITER_W)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .num     (num),
    .modulus (modulus),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .inv     (inv),
    .gcd     (gcd),
    .err     (err),
    .iters   (iters)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present operands for one edge; the caller guarantees the engine is idle.
  task automatic start(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m);
    s_valid = 1'b1;
    num     = n;
    modulus = m;
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
  endtask

  // Counts edges after the acceptance edge until m_valid; bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_valid && lat < 400) begin
      @(posedge aclk);
      #1;
      lat++;
    end
  endtask

  task automatic check_res(input string name, input int lat, input int exp_lat,
                           input logic [WIDTH-1:0] e_inv, input logic [WIDTH-1:0] e_gcd,
                           input logic e_err, input int e_iters);
    check({name, ".lat"},   lat,   exp_lat);
    check({name, ".inv"},   inv,   e_inv);
    check({name, ".gcd"},   gcd,   e_gcd);
    check({name, ".err"},   err,   e_err);
    check({name, ".iters"}, iters, e_iters);
  endtask

  task automatic txn(input string name, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m,
                     input logic [WIDTH-1:0] e_inv, input logic [WIDTH-1:0] e_gcd,
                     input logic e_err, input int e_iters, input int e_lat);
    int lat;
    start(n, m);
    wait_valid(lat);
    check_res(name, lat, e_lat, e_inv, e_gcd, e_err, e_iters);
    @(posedge aclk);
    #1;
    check({name, ".mvalid_1cyc"}, m_valid, 1'b0);
    check({name, ".sready_back"}, s_ready, 1'b1);
  endtask

  initial begin
    int lat;
    areset  = 1'b1;
    s_valid = 1'b0;
    num     = '0;
    modulus = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("rst.s_ready", s_ready, 1'b1);
    check("rst.m_valid", m_valid, 1'b0);
    check("rst.inv",     inv,     0);
    check("rst.gcd",     gcd,     0);
    check("rst.err",     err,     1'b0);
    check("rst.iters",   iters,   0);
    areset = 1'b0;

    txn("inv3_11",    8'd3,   8'd11,  8'd4,   8'd1, 1'b0, 3, 32);
    txn("inv14_11",   8'd14,  8'd11,  8'd4,   8'd1, 1'b0, 5, 52);
    txn("gcd6_9",     8'd6,   8'd9,   8'd0,   8'd3, 1'b1, 2, 22);
    txn("zero_9",     8'd0,   8'd9,   8'd0,   8'd9, 1'b1, 0, 2);
    txn("mod1",       8'd5,   8'd1,   8'd0,   8'd1, 1'b1, 0, 2);
    txn("inv254_255", 8'd254, 8'd255, 8'd254, 8'd1, 1'b0, 2, 22);
    txn("one_11",     8'd1,   8'd11,  8'd1,   8'd1, 1'b0, 1, 12);
    txn("m1_11",      8'd10,  8'd11,  8'd10,  8'd1, 1'b0, 2, 22);

    // Backpressure: result held while new operands are offered and ignored.
    m_ready = 1'b0;
    start(8'd3, 8'd11);
    wait_valid(lat);
    check_res("bp", lat, 32, 8'd4, 8'd1, 1'b0, 3);
    s_valid = 1'b1;
    num     = 8'd5;
    modulus = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk);
      #1;
      check("bp.hold_mvalid", m_valid, 1'b1);
      check("bp.hold_sready", s_ready, 1'b0);
      check("bp.hold_inv",    inv,     8'd4);
      check("bp.hold_iters",  iters,   3);
    end
    m_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("bp.idle_sready", s_ready, 1'b1);
    check("bp.idle_mvalid", m_valid, 1'b0);
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    check("bp.next_accept", s_ready, 1'b0);
    wait_valid(lat);
    check_res("inv5_7", lat, 32, 8'd3, 8'd1, 1'b0, 3);
    @(posedge aclk);
    #1;

    // Reset four cycles into DIV, with s_valid asserted on the reset edge.
    start(8'd3, 8'd11);
    repeat (5) @(posedge aclk);
    #1;
    areset  = 1'b1;
    s_valid = 1'b1;
    num     = 8'd5;
    modulus = 8'd7;
    @(posedge aclk);
    #1;
    areset  = 1'b0;
    s_valid = 1'b0;
    check("mrst.s_ready", s_ready, 1'b1);
    check("mrst.m_valid", m_valid, 1'b0);
    check("mrst.inv",     inv,     0);
    check("mrst.gcd",     gcd,     0);
    check("mrst.err",     err,     1'b0);
    check("mrst.iters",   iters,   0);
    txn("post_rst", 8'd3, 8'd11, 8'd4, 8'd1, 1'b0, 3, 32);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
